cgra_top: RTL and testbench



---
 rtl/cgra_pkg.sv | 43 ++++
 rtl/cgra_if.sv | 7 +
 rtl/cgra_pe.sv | 34 +++
 rtl/cgra_top.sv | 105 ++++++++++
 tb/tb_cgra_top.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/cgra_pkg.sv
// Shared types and constants for the single-tile CGRA: op/source encodings,
// config register addresses and the PE config layout.
package cgra_pkg;
  localparam int WORD_W = 16;
  localparam logic [31:0] PE_CFG_ADDR  = 32'h0;
  localparam logic [31:0] OUT_CFG_ADDR = 32'h1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_MUL   = 4'd6,
    OP_PASS  = 4'd7,
    OP_CONST = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    SRC_S2 = 2'd0,
    SRC_S3 = 2'd1,
    SRC_S0 = 2'd2,
    SRC_S1 = 2'd3
  } src_e;

  typedef struct packed {
    logic [WORD_W-1:0] cnst;
    logic [3:0]        op;
    src_e              src_b;
    src_e              src_a;
  } pe_cfg_t;

  function automatic logic [WORD_W-1:0] src_sel(input src_e s,
      input logic [WORD_W-1:0] s0, s1, s2, s3);
    case (s)
      SRC_S2:  src_sel = s2;
      SRC_S3:  src_sel = s3;
      SRC_S0:  src_sel = s0;
      default: src_sel = s1;
    endcase
  endfunction
endpackage

// File: rtl/cgra_if.sv
// Configuration address/data bus; sampled by the tile on every rising edge.
interface cgra_if;
  logic [31:0] config_addr_in;
  logic [31:0] config_data_in;
  modport master (output config_addr_in, output config_data_in);
  modport slave  (input  config_addr_in, input  config_data_in);
endinterface

// File: rtl/cgra_pe.sv
// Combinational PE ALU. The 16x16 multiplier exists only when CGRA_MUL_EN is
// defined; otherwise OP_MUL returns zero like the unused opcodes.
module cgra_pe
  import cgra_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] cnst,
  input  logic [3:0]        op,
  output logic [WORD_W-1:0] res
);
`ifdef CGRA_MUL_EN
  logic [2*WORD_W-1:0] prod;
  assign prod = a * b;
`endif

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:   res = a + b;
      OP_SUB:   res = a - b;
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_SHL:   res = a << cnst[3:0];
`ifdef CGRA_MUL_EN
      OP_MUL:   res = prod[WORD_W-1:0];
`endif
      OP_PASS:  res = a;
      OP_CONST: res = cnst;
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/cgra_top.sv
// Single-tile CGRA top: gathers pad sides into words (T0 = MSB), runs one
// configurable PE op and registers the result onto S0 pads. Optional: CGRA_MUL_EN.
module cgra_top
  import cgra_pkg::*;
(
  input  logic clk_in,
  input  logic reset_in,
  cgra_if.slave cfg,
  input  logic pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in,
  input  logic pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
  input  logic pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in,
  input  logic pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
  input  logic pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in,
  input  logic pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
  input  logic pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in,
  input  logic pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
  input  logic pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in,
  input  logic pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
  input  logic pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in,
  input  logic pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
  input  logic pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in,
  input  logic pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
  input  logic pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in,
  input  logic pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in,
  output logic pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out,
  output logic pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
  output logic pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out,
  output logic pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
  input  logic tdi,
  input  logic tms,
  input  logic tck,
  input  logic trst_n,
  output logic tdo
);
  logic [WORD_W-1:0] s0_w, s1_w, s2_w, s3_w, a_w, b_w, alu_w;
  pe_cfg_t           pe_cfg_q, pe_cfg_d;
  logic              out_hold_q, out_hold_d;
  logic [WORD_W-1:0] out_q, out_d;

  assign s0_w = {pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in,
                 pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
                 pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in,
                 pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
  assign s1_w = {pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in,
                 pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
                 pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in,
                 pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
  assign s2_w = {pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in,
                 pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
                 pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in,
                 pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
  assign s3_w = {pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in,
                 pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
                 pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in,
                 pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

  assign a_w = src_sel(pe_cfg_q.src_a, s0_w, s1_w, s2_w, s3_w);
  assign b_w = src_sel(pe_cfg_q.src_b, s0_w, s1_w, s2_w, s3_w);

  cgra_pe u_pe (
    .a    (a_w),
    .b    (b_w),
    .cnst (pe_cfg_q.cnst),
    .op   (pe_cfg_q.op),
    .res  (alu_w)
  );

  // No write strobe: the addressed register reloads on every edge.
  always_comb begin
    pe_cfg_d   = pe_cfg_q;
    out_hold_d = out_hold_q;
    if (cfg.config_addr_in == PE_CFG_ADDR)
      pe_cfg_d = '{cnst:  cfg.config_data_in[31:16],
                   op:    cfg.config_data_in[7:4],
                   src_b: src_e'(cfg.config_data_in[3:2]),
                   src_a: src_e'(cfg.config_data_in[1:0])};
    if (cfg.config_addr_in == OUT_CFG_ADDR)
      out_hold_d = cfg.config_data_in[0];
    out_d = out_hold_q ? out_q : alu_w;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pe_cfg_q   <= '0;
      out_hold_q <= 1'b0;
      out_q      <= '0;
    end else begin
      pe_cfg_q   <= pe_cfg_d;
      out_hold_q <= out_hold_d;
      out_q      <= out_d;
    end
  end

  assign {pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out,
          pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
          pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out,
          pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = out_q;

  assign tdo = 1'b0;

  // JTAG pins and reserved config bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{tdi, tms, tck, trst_n, cfg.config_data_in[15:8],
                       cfg.config_data_in[31:1]};
endmodule

// File: tb/tb_cgra_top.sv
// Directed bench for cgra_top: expected words are queued when stimulus is
// driven and popped/compared one cycle later when the result register updates.
module tb_cgra_top;
  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [15:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  wire  [15:0] ow;
  wire         tdo;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct { logic [15:0] v; string tag; } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] c;
    logic [15:0] a0, a1, a2, a3, e;
  } vec_t;

  cgra_if cif();

  always #5 clk_in = ~clk_in;

  cgra_top dut (
    .clk_in(clk_in), .reset_in(reset_in), .cfg(cif.slave),
    .pad_S0_T0_in(s0[15]), .pad_S0_T1_in(s0[14]), .pad_S0_T2_in(s0[13]), .pad_S0_T3_in(s0[12]),
    .pad_S0_T4_in(s0[11]), .pad_S0_T5_in(s0[10]), .pad_S0_T6_in(s0[9]), .pad_S0_T7_in(s0[8]),
    .pad_S0_T8_in(s0[7]), .pad_S0_T9_in(s0[6]), .pad_S0_T10_in(s0[5]), .pad_S0_T11_in(s0[4]),
    .pad_S0_T12_in(s0[3]), .pad_S0_T13_in(s0[2]), .pad_S0_T14_in(s0[1]), .pad_S0_T15_in(s0[0]),
    .pad_S1_T0_in(s1[15]), .pad_S1_T1_in(s1[14]), .pad_S1_T2_in(s1[13]), .pad_S1_T3_in(s1[12]),
    .pad_S1_T4_in(s1[11]), .pad_S1_T5_in(s1[10]), .pad_S1_T6_in(s1[9]), .pad_S1_T7_in(s1[8]),
    .pad_S1_T8_in(s1[7]), .pad_S1_T9_in(s1[6]), .pad_S1_T10_in(s1[5]), .pad_S1_T11_in(s1[4]),
    .pad_S1_T12_in(s1[3]), .pad_S1_T13_in(s1[2]), .pad_S1_T14_in(s1[1]), .pad_S1_T15_in(s1[0]),
    .pad_S2_T0_in(s2[15]), .pad_S2_T1_in(s2[14]), .pad_S2_T2_in(s2[13]), .pad_S2_T3_in(s2[12]),
    .pad_S2_T4_in(s2[11]), .pad_S2_T5_in(s2[10]), .pad_S2_T6_in(s2[9]), .pad_S2_T7_in(s2[8]),
    .pad_S2_T8_in(s2[7]), .pad_S2_T9_in(s2[6]), .pad_S2_T10_in(s2[5]), .pad_S2_T11_in(s2[4]),
    .pad_S2_T12_in(s2[3]), .pad_S2_T13_in(s2[2]), .pad_S2_T14_in(s2[1]), .pad_S2_T15_in(s2[0]),
    .pad_S3_T0_in(s3[15]), .pad_S3_T1_in(s3[14]), .pad_S3_T2_in(s3[13]), .pad_S3_T3_in(s3[12]),
    .pad_S3_T4_in(s3[11]), .pad_S3_T5_in(s3[10]), .pad_S3_T6_in(s3[9]), .pad_S3_T7_in(s3[8]),
    .pad_S3_T8_in(s3[7]), .pad_S3_T9_in(s3[6]), .pad_S3_T10_in(s3[5]), .pad_S3_T11_in(s3[4]),
    .pad_S3_T12_in(s3[3]), .pad_S3_T13_in(s3[2]), .pad_S3_T14_in(s3[1]), .pad_S3_T15_in(s3[0]),
    .pad_S0_T0_out(ow[15]), .pad_S0_T1_out(ow[14]), .pad_S0_T2_out(ow[13]), .pad_S0_T3_out(ow[12]),
    .pad_S0_T4_out(ow[11]), .pad_S0_T5_out(ow[10]), .pad_S0_T6_out(ow[9]), .pad_S0_T7_out(ow[8]),
    .pad_S0_T8_out(ow[7]), .pad_S0_T9_out(ow[6]), .pad_S0_T10_out(ow[5]), .pad_S0_T11_out(ow[4]),
    .pad_S0_T12_out(ow[3]), .pad_S0_T13_out(ow[2]), .pad_S0_T14_out(ow[1]), .pad_S0_T15_out(ow[0]),
    .tdi(1'b0), .tms(1'b0), .tck(1'b0), .trst_n(1'b1), .tdo(tdo)
  );

  task automatic check(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cif.config_addr_in = a;
    cif.config_data_in = d;
  endtask

  task automatic idle();
    wr(32'hFFFF_FFFF, 32'hDEAD_BEEF);
  endtask

  // One clock; when chk is set the expected word is queued and compared at #1.
  task automatic cyc(input bit chk, input logic [15:0] e, input string tag);
    sb_t ent;
    if (chk) sb.push_back('{v: e, tag: tag});
    @(posedge clk_in);
    #1;
    if (chk) begin
      ent = sb.pop_front();
      check(ow, ent.v, ent.tag);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{c: 32'h0000_000E, a0: 16'hFFFF, a1: 16'h0002, a2: 16'h0, a3: 16'h0, e: 16'h0001};
    tbl[1] = '{c: 32'h0000_0024, a0: 16'h0, a1: 16'h0, a2: 16'hF0F0, a3: 16'hFF00, e: 16'hF000};
    tbl[2] = '{c: 32'h0000_0034, a0: 16'h0, a1: 16'h0, a2: 16'hF0F0, a3: 16'hFF00, e: 16'hFFF0};
    tbl[3] = '{c: 32'h0000_0044, a0: 16'h0, a1: 16'h0, a2: 16'hF0F0, a3: 16'hFF00, e: 16'h0FF0};
    tbl[4] = '{c: 32'h0000_0073, a0: 16'h0, a1: 16'hBEEF, a2: 16'h1111, a3: 16'h0, e: 16'hBEEF};
    tbl[5] = '{c: 32'hABCD_0080, a0: 16'h1, a1: 16'h2, a2: 16'h3, a3: 16'h4, e: 16'hABCD};
    tbl[6] = '{c: 32'hABCD_0090, a0: 16'h1, a1: 16'h2, a2: 16'h3, a3: 16'h4, e: 16'h0000};
    tbl[7] = '{c: 32'h000F_0052, a0: 16'h0003, a1: 16'h0, a2: 16'h0, a3: 16'h0, e: 16'h8000};

    // No reset: zero config from the first edge gives doubling from edge 2.
    wr(32'h0, 32'h0);
    s2 = 16'd3;
    cyc(0, '0, "");
    cyc(1, 16'd6, "noreset_x2");
    repeat (50) cyc(0, '0, "");
    cyc(1, 16'd6, "noreset_long");
    s2 = 16'h8001;
    cyc(1, 16'h0002, "noreset_wrap");

    // Asynchronous reset clears output with no clock edge.
    reset_in = 1'b1;
    s2 = 16'd3;
    #1;
    check(ow, 16'h0, "rst_async_out");
    check({15'd0, tdo}, 16'h0, "rst_tdo");
    cyc(1, 16'h0, "rst_held");
    reset_in = 1'b0;
    cyc(1, 16'd6, "post_rst_x2");

    // SUB S2-S3; idle address with junk data must not disturb the config.
    wr(32'h0, 32'h0000_0014);
    cyc(1, 16'd6, "sub_wr_old_cfg");
    idle();
    s2 = 16'd10; s3 = 16'd3;
    cyc(1, 16'd7, "sub_10_3");
    s2 = 16'd3; s3 = 16'd10;
    cyc(1, 16'hFFF9, "sub_borrow");

    // SHL by CONST, then freeze with OUT_HOLD.
    wr(32'h0, 32'h0004_0050);
    cyc(0, '0, "");
    idle();
    s2 = 16'h0123;
    cyc(1, 16'h1230, "shl4");
    wr(32'h1, 32'h0000_0001);
    cyc(1, 16'h1230, "hold_wr");
    idle();
    s2 = 16'h0FFF;
    cyc(1, 16'h1230, "hold_frozen");
    cyc(1, 16'h1230, "hold_frozen2");
    wr(32'h1, 32'h0);
    cyc(1, 16'h1230, "hold_release_edge");
    idle();
    cyc(1, 16'hFFF0, "hold_released");

    // MUL: present only with CGRA_MUL_EN.
    s2 = 16'd300; s3 = 16'd300;
    wr(32'h0, 32'h0000_0064);
    cyc(0, '0, "");
    idle();
`ifdef CGRA_MUL_EN
    cyc(1, 16'h5F90, "mul_300x300");
`else
    cyc(1, 16'h0000, "mul_disabled");
`endif

    for (int i = 0; i < 8; i++) begin
      s0 = tbl[i].a0; s1 = tbl[i].a1; s2 = tbl[i].a2; s3 = tbl[i].a3;
      wr(32'h0, tbl[i].c);
      cyc(0, '0, "");
      idle();
      cyc(1, tbl[i].e, $sformatf("tbl%0d", i));
    end

    // Mid-stream reset with non-zero output; config must revert to doubling.
    s2 = 16'd3;
    reset_in = 1'b1;
    #2;
    check(ow, 16'h0, "midrst_out");
    reset_in = 1'b0;
    idle();
    cyc(1, 16'd6, "midrst_cfg_revert");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
